// File: rtl/requant_pack_pkg.sv
// Shared constants and the configuration record for the requantise-and-pack datapath.
package requant_pack_pkg;

  localparam int OUT_LANES = 4;

  localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;

  // Q31 doubling-high-multiply rounding terms; Q31_TRUNC biases negatives so >>> truncates toward zero
  localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
  localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;
  localparam logic signed [63:0] Q31_TRUNC = 64'sd2147483647;

  typedef struct packed {
    logic [31:0] multiplier;
    logic [5:0]  shift;
    logic [31:0] outOffset;
    logic [7:0]  actMin;
    logic [7:0]  actMax;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{multiplier: 32'h4000_0000, shift: 6'd0, outOffset: 32'd0,
                                 actMin: 8'h80, actMax: 8'h7F};

endpackage

// File: rtl/requant_pack_if.sv
// Element-in / packed-word-out stream bundle between a producer and requant_pack.
interface requant_pack_if;
  import requant_pack_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_acc;
  logic [31:0]            in_bias;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [8*OUT_LANES-1:0] out_data;
  logic [OUT_LANES-1:0]   out_keep;

  modport master (
    output in_valid, in_acc, in_bias, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep
  );

  modport slave (
    input  in_valid, in_acc, in_bias, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep
  );

endinterface

// File: rtl/requant_pack_core.sv
// Four-stage int32 -> int8 requantisation pipeline; every stage holds while i_en is low.
module requant_core
  import requant_pack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_valid,
  input  logic [31:0] i_acc,
  input  logic [31:0] i_bias,
  input  logic        i_last,
  input  cfg_t        i_cfg,
  output logic        o_valid,
  output logic        o_last,
  output logic [7:0]  o_data,
  output logic        o_busy
);

  logic [3:0]         r_valid;
  logic [3:0]         r_last;
  logic signed [31:0] r_x;
  logic signed [31:0] r_y;
  logic signed [31:0] r_z;
  logic [7:0]         r_q;

  logic signed [5:0]  w_shift;
  logic signed [31:0] w_mult;
  logic [31:0]        w_sum;
  logic [31:0]        w_x;
  logic signed [63:0] w_prod;
  logic signed [63:0] w_round;
  logic signed [63:0] w_trunc;
  logic signed [63:0] w_q31;
  logic signed [31:0] w_y;
  logic [5:0]         w_n;
  logic [63:0]        w_mask64;
  logic [31:0]        w_mask;
  logic [31:0]        w_rem;
  logic [31:0]        w_thr;
  logic signed [63:0] w_ext;
  logic signed [31:0] w_z;
  logic signed [31:0] w_off;
  logic signed [31:0] w_lo;
  logic signed [31:0] w_hi;
  logic signed [31:0] w_clampLo;
  logic signed [31:0] w_clamp;

  assign w_shift = $signed(i_cfg.shift);
  assign w_mult  = $signed(i_cfg.multiplier);

  assign w_sum = i_acc + i_bias;
  assign w_x   = (w_shift > 6'sd0) ? (w_sum << w_shift[4:0]) : w_sum;

  assign w_prod  = 64'(r_x) * 64'(w_mult);
  assign w_round = w_prod + ((w_prod >= 64'sd0) ? NUDGE_POS : NUDGE_NEG);
  assign w_trunc = (w_round < 64'sd0) ? (w_round + Q31_TRUNC) : w_round;
  assign w_q31   = w_trunc >>> 31;
  assign w_y     = (r_x == INT32_MIN && w_mult == INT32_MIN) ? INT32_MAX : w_q31[31:0];

  // 64-bit working width keeps the n == 32 case (cfg_shift = -32) well defined
  assign w_n      = 6'(-w_shift);
  assign w_mask64 = (64'd1 << w_n) - 64'd1;
  assign w_mask   = w_mask64[31:0];
  assign w_rem    = r_y & w_mask;
  assign w_thr    = {1'b0, w_mask[31:1]} + {31'd0, r_y[31]};
  assign w_ext    = 64'(r_y) >>> w_n;
  assign w_z      = (w_shift < 6'sd0) ? (w_ext[31:0] + {31'd0, (w_rem > w_thr)}) : r_y;

  // Upper bound applied last so an inverted range collapses onto actMax
  assign w_off     = r_z + $signed(i_cfg.outOffset);
  assign w_lo      = 32'($signed(i_cfg.actMin));
  assign w_hi      = 32'($signed(i_cfg.actMax));
  assign w_clampLo = (w_off < w_lo) ? w_lo : w_off;
  assign w_clamp   = (w_clampLo > w_hi) ? w_hi : w_clampLo;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
      r_last  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_q     <= '0;
    end else if (i_en) begin
      r_valid <= {r_valid[2:0], i_valid};
      r_last  <= {r_last[2:0], i_valid & i_last};
      r_x     <= w_x;
      r_y     <= w_y;
      r_z     <= w_z;
      r_q     <= w_clamp[7:0];
    end
  end

  assign o_valid = r_valid[3];
  assign o_last  = r_last[3];
  assign o_data  = r_q;
  assign o_busy  = |r_valid;

endmodule

// File: rtl/requant_pack.sv
// Requantises int32 accumulators to int8 and packs OUT_LANES results per output word.
module requant_pack
  import requant_pack_pkg::*;
#(
  parameter int OUT_LANES = requant_pack_pkg::OUT_LANES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [31:0]        cfg_multiplier,
  input  logic [5:0]         cfg_shift,
  input  logic [31:0]        cfg_out_offset,
  input  logic [7:0]         cfg_act_min,
  input  logic [7:0]         cfg_act_max,
  requant_pack_if.slave      bus,
  output logic               busy
);

  localparam int CNT_W = $clog2(OUT_LANES);

  cfg_t                   r_cfg;
  logic [CNT_W-1:0]       r_laneCnt;
  logic [8*OUT_LANES-1:0] r_data;
  logic [OUT_LANES-1:0]   r_keep;
  logic                   r_outValid;

  logic                   w_stall;
  logic                   w_accept;
  logic                   w_coreValid;
  logic                   w_coreLast;
  logic [7:0]             w_coreData;
  logic                   w_coreBusy;
  logic                   w_wordDone;
  logic [8*OUT_LANES-1:0] w_nextData;
  logic [OUT_LANES-1:0]   w_nextKeep;

  assign w_stall  = r_outValid && !bus.out_ready;
  assign w_accept = bus.in_valid && !w_stall;

  requant_core u_core (
    .clk     (clk),
    .reset   (reset),
    .i_en    (!w_stall),
    .i_valid (w_accept),
    .i_acc   (bus.in_acc),
    .i_bias  (bus.in_bias),
    .i_last  (bus.in_last),
    .i_cfg   (r_cfg),
    .o_valid (w_coreValid),
    .o_last  (w_coreLast),
    .o_data  (w_coreData),
    .o_busy  (w_coreBusy)
  );

  assign busy = w_coreBusy || r_outValid || (r_laneCnt != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cfg <= CFG_RESET;
    end else if (cfg_we && !busy) begin
      r_cfg <= '{multiplier: cfg_multiplier, shift: cfg_shift, outOffset: cfg_out_offset,
                 actMin: cfg_act_min, actMax: cfg_act_max};
    end
  end

  // Lane 0 starts from a cleared word so a short tile leaves its unused lanes zero
  always_comb begin
    w_nextData = (r_laneCnt == '0) ? '0 : r_data;
    w_nextKeep = (r_laneCnt == '0) ? '0 : r_keep;
    for (int k = 0; k < OUT_LANES; k++) begin
      if (int'(r_laneCnt) == k) begin
        w_nextData[8*k +: 8] = w_coreData;
        w_nextKeep[k]        = 1'b1;
      end
    end
  end

  assign w_wordDone = w_coreLast || (int'(r_laneCnt) == OUT_LANES - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_laneCnt  <= '0;
      r_data     <= '0;
      r_keep     <= '0;
      r_outValid <= 1'b0;
    end else if (!w_stall) begin
      if (w_coreValid) begin
        r_data     <= w_nextData;
        r_keep     <= w_nextKeep;
        r_outValid <= w_wordDone;
        r_laneCnt  <= w_wordDone ? '0 : r_laneCnt + 1'b1;
      end else begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_data;
  assign bus.out_keep  = r_keep;

endmodule

// File: tb/tb_requant_pack.sv
// Directed bench for requant_pack: a reference model fills a word scoreboard as elements are accepted.
module tb_requant_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_multiplier = '0;
  logic [5:0]  cfg_shift = '0;
  logic [31:0] cfg_out_offset = '0;
  logic [7:0]  cfg_act_min = '0;
  logic [7:0]  cfg_act_max = '0;
  logic        busy;

  requant_pack_if bus();

  requant_pack #(.OUT_LANES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_multiplier (cfg_multiplier),
    .cfg_shift      (cfg_shift),
    .cfg_out_offset (cfg_out_offset),
    .cfg_act_min    (cfg_act_min),
    .cfg_act_max    (cfg_act_max),
    .bus            (bus),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int          cmpCount = 0;
  int          errCount = 0;
  logic [35:0] expQ[$];
  logic [31:0] tbLanes = '0;
  int          tbCnt = 0;
  int          tbMult, tbShift, tbOffset, tbMin, tbMax;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic failTimeout(input string tag);
    cmpCount++;
    errCount++;
    $error("[TB] FAIL %s: observed=timeout expected=progress", tag);
  endtask

  task automatic defaultShadow();
    tbMult = 32'h4000_0000; tbShift = 0; tbOffset = 0; tbMin = -128; tbMax = 127;
  endtask

  function automatic logic [7:0] modelLane(input int acc, input int bias);
    int     x, y, w, res;
    longint p, d, q, r;
    x = acc + bias;
    if (tbShift > 0) x = x << tbShift;
    if (x == int'(32'h8000_0000) && tbMult == int'(32'h8000_0000)) begin
      y = int'(32'h7FFF_FFFF);
    end else begin
      p = longint'(x) * longint'(tbMult);
      p = p + ((p >= 0) ? 64'sd1073741824 : -64'sd1073741823);
      y = int'(p / 64'sd2147483648);
    end
    if (tbShift < 0) begin
      d = 64'sd1 <<< (-tbShift);
      q = longint'(y) / d;
      r = longint'(y) - q * d;
      if (2 * ((r < 0) ? -r : r) >= d) q = q + ((y < 0) ? -1 : 1);
      y = int'(q);
    end
    w = y + tbOffset;
    if (tbMin > tbMax)   res = tbMax;
    else if (w < tbMin)  res = tbMin;
    else if (w > tbMax)  res = tbMax;
    else                 res = w;
    return res[7:0];
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic applyStimulus(input int acc, input int bias, input bit last, input bit track);
    bit ok = 0;
    bit rdy;
    logic [3:0] k;
    bus.in_valid = 1'b1;
    bus.in_acc   = acc;
    bus.in_bias  = bias;
    bus.in_last  = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      ok = rdy;
    end
    if (!ok) begin
      failTimeout("in_accept");
    end else if (track) begin
      tbLanes[8*tbCnt +: 8] = modelLane(acc, bias);
      tbCnt++;
      if (tbCnt == 4 || last) begin
        k = 4'((1 << tbCnt) - 1);
        expQ.push_back({k, tbLanes});
        tbLanes = '0;
        tbCnt = 0;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic setCfg(input int mult, input int shift, input int offset,
                        input int amin, input int amax, input bit expectTaken);
    cfg_multiplier = mult;
    cfg_shift      = 6'(shift);
    cfg_out_offset = offset;
    cfg_act_min    = 8'(amin);
    cfg_act_max    = 8'(amax);
    cfg_we         = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (expectTaken) begin
      tbMult = mult; tbShift = shift; tbOffset = offset; tbMin = amin; tbMax = amax;
    end
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = !busy && (expQ.size() == 0);
    end
    if (!done) failTimeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    logic [35:0] e;
    if (reset && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        cmpCount++;
        errCount++;
        $error("[TB] FAIL unexpected_word: observed=%h expected=none", bus.out_data);
      end else begin
        e = expQ.pop_front();
        checkOutput("word_data", bus.out_data, e[31:0]);
        checkOutput("word_keep", {28'd0, bus.out_keep}, {28'd0, e[35:32]});
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_acc    = '0;
    bus.in_bias   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    defaultShadow();

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_out_keep", 32'(bus.out_keep), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic requant, latency and busy");
    setCfg(32'h4000_0000, 0, -128, -128, 127, 1);
    applyStimulus(100, 28, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("lat_early", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("lat_data", bus.out_data, 32'h0000_00C0);
    checkOutput("busy_held", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_fall", 32'(busy), 32'd0);
    waitIdle();

    $display("[TB] rounding right shift");
    setCfg(32'h4000_0000, -1, 0, -128, 127, 1);
    applyStimulus(100, 28, 1, 1);
    waitIdle();
    setCfg(32'h7FFF_FFFF, -1, 0, -128, 127, 1);
    applyStimulus(-3, 0, 1, 1);
    waitIdle();

    $display("[TB] saturating multiply");
    setCfg(32'h8000_0000, 0, 0, -128, 127, 1);
    applyStimulus(int'(32'h8000_0000), 0, 1, 1);
    waitIdle();

    $display("[TB] stream of six with partial word");
    setCfg(32'h7FFF_FFFF, 0, 0, -128, 127, 1);
    for (int v = 1; v <= 6; v++) applyStimulus(v, 0, v == 6, 1);
    waitIdle();

    $display("[TB] output backpressure");
    bus.out_ready = 1'b0;
    for (int v = 1; v <= 8; v++) applyStimulus(v, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("stall_data", bus.out_data, 32'h0403_0201);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resume_gap", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("resume_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("resume_data", bus.out_data, 32'h0807_0605);
    @(posedge clk);
    #1;
    for (int v = 9; v <= 12; v++) applyStimulus(v, 0, v == 12, 1);
    waitIdle();

    $display("[TB] cfg write ignored while busy");
    applyStimulus(20, 0, 0, 1);
    setCfg(0, 0, 0, -128, 127, 0);
    applyStimulus(21, 0, 1, 1);
    waitIdle();
    applyStimulus(7, 0, 1, 1);
    waitIdle();

    $display("[TB] clamping with random values");
    setCfg(32'h0123_4567, -5, 7, -20, 50, 1);
    for (int i = 0; i < 9; i++)
      applyStimulus(int'($urandom_range(0, 200000)) - 100000, int'($urandom_range(0, 2000)) - 1000, i == 8, 1);
    waitIdle();
    setCfg(32'h3000_0000, 3, -5, -128, 127, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus(int'($urandom_range(0, 200)) - 100, 0, i == 3, 1);
    waitIdle();

    $display("[TB] inverted activation range");
    setCfg(32'h7FFF_FFFF, 0, 0, 10, -10, 1);
    applyStimulus(-50, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(50, 0, 1, 1);
    waitIdle();

    $display("[TB] reset mid-tile");
    setCfg(32'h7FFF_FFFF, 0, 0, -128, 127, 1);
    for (int v = 1; v <= 5; v++) applyStimulus(v, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b1;
    defaultShadow();
    tbCnt = 0;
    tbLanes = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("midrst_quiet", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(10, 0, 0, 1);
    applyStimulus(12, 0, 0, 1);
    applyStimulus(14, 0, 1, 1);
    waitIdle();

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/requant_pack.md
REQUANT_PACK -- requirements
Module: requant_pack

Interface
REQ-001 SHALL have parameter OUT_LANES, default 4, meaning int8 results packed per output word (fixed 4; other values unsupported).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port cfg_we  input  1  load pulse for the cfg_* values below.
REQ-005 SHALL have ports cfg_multiplier input 32 (signed Q31), cfg_shift input 6 (signed; >0 left, <0 right), cfg_out_offset input 32 (signed), cfg_act_min input 8 (signed), cfg_act_max input 8 (signed).
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_acc input 32 (signed accumulator), in_bias input 32 (signed), in_last input 1 (final element of tile).
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, out_data output 32 (lane k in bits [8k+7:8k]), out_keep output 4 (lane-valid mask).
REQ-008 SHALL have port busy output 1, high while any pipeline stage or packer holds data.

Function
REQ-009 SHALL latch all cfg_* registers on cfg_we only when busy=0; cfg_we while busy=1 SHALL be ignored.
REQ-010 SHALL accept an element when in_valid && in_ready; in_ready = !(out_valid && !out_ready).
REQ-011 SHALL stall every stage, valid bits included, in any cycle with out_valid && !out_ready.
REQ-012 S1: x = in_acc + in_bias, 32-bit wrap; if cfg_shift>0, x = x << cfg_shift, 32-bit wrap.
REQ-013 S2: doubling-high multiply; if x == multiplier == INT32_MIN result SHALL be INT32_MAX; else p = x*multiplier (64-bit signed), nudge = 2^30 if p>=0 else 1-2^30, result = (p+nudge)/2^31 truncated toward zero.
REQ-014 S3: if cfg_shift<0, n = -cfg_shift, mask = 2^n-1, rem = y & mask, thr = (mask>>1) + (y<0); result = (y>>>n) + (rem>thr); else pass-through.
REQ-015 S4: z + cfg_out_offset (32-bit), clamped to [cfg_act_min, cfg_act_max], truncated to 8 bits.
REQ-016 Latency: accepted element SHALL be written into packer lane 4 cycles after acceptance (no stall).
REQ-017 Packer SHALL fill lanes 0..3 in arrival order; word SHALL become out_valid the cycle after lane 3 written or after an in_last element written.
REQ-018 Partial word (in_last) SHALL zero unused lanes and set out_keep to contiguous low-lane mask (e.g. 3 lanes -> 4'b0111); full word out_keep=4'b1111.
REQ-019 out_data/out_keep SHALL hold stable while out_valid && !out_ready.
REQ-020 On out_valid && out_ready the packer SHALL, in the same cycle, accept a lane arriving from S4 into lane 0 of the next word (no bubble).
REQ-021 Lane counter SHALL wrap 3->0 after full word and reset to 0 after in_last word.
REQ-022 busy SHALL fall the cycle after the last word handshakes with no element in flight.
REQ-023 cfg_act_min > cfg_act_max is not a supported configuration; output then SHALL equal cfg_act_max.

Reset
REQ-024 With reset=0 at clk edge: all stage valids, lane counter = 0; out_valid=0, out_data=0, out_keep=0, busy=0, in_ready=1.
REQ-025 cfg registers reset to multiplier=0x40000000, shift=0, out_offset=0, act_min=-128, act_max=127.
REQ-026 Reset mid-operation SHALL discard all in-flight elements and any partial word without emitting it.

Structure
REQ-027 Shared package SHALL hold INT32_MIN/INT32_MAX, Q31 nudge constants, OUT_LANES, and the cfg record typedef.
REQ-028 Arithmetic S1-S4 SHALL be one sub-module requant_core (pure pipeline with stall enable); packer and handshake stay in requant_pack.

Verification
REQ-029 acc=100, bias=28, mult=0x40000000, shift=0, offset=-128 -> lane value 0xC0 (-64).
REQ-030 Same, shift=-1, offset=0 -> 32 (0x20); y=-3 with shift=-1 -> -2 (round half away from zero).
REQ-031 acc=INT32_MIN, bias=0, mult=INT32_MIN, shift=0, offset=0, range [-128,127] -> 127.
REQ-032 Stream 6 elements values 1..6 (mult=0x7FFFFFFF), last on 6th -> words 0x04030201 keep 1111, then 0x00000605 keep 0011.
REQ-033 Hold out_ready=0 10 cycles mid-stream -> in_ready=0, out_data stable, no loss or duplication; then back-to-back words with no bubble.
REQ-034 Assert reset=0 with 2 lanes packed and 3 in flight -> no word emitted; next tile starts at lane 0.
